// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command engine: opcodes, FSM states and
// the layout of the STATUS readback word.
package spi_cmd_pkg;

    localparam int OP_W = 4;
    localparam int CH_W = 4;

    localparam logic [OP_W-1:0] OP_EN_SET  = 4'd1;
    localparam logic [OP_W-1:0] OP_EN_CLR  = 4'd2;
    localparam logic [OP_W-1:0] OP_MEM_WR  = 4'd3;
    localparam logic [OP_W-1:0] OP_MEM_RD  = 4'd4;
    localparam logic [OP_W-1:0] OP_REV     = 4'd5;
    localparam logic [OP_W-1:0] OP_STATUS  = 4'd6;
    localparam logic [OP_W-1:0] OP_ERR_CLR = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WDATA = 3'd3,
        ST_RDATA = 3'd4
    } state_e;

    // STATUS word: ERR at the MSB, state just below it, enables at the LSBs.
    localparam int ST_ERR_FROM_MSB   = 0;
    localparam int ST_STATE_FROM_MSB = 1;
    localparam int ST_STATE_W        = 3;
    localparam int ST_EN_LSB         = 0;

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address counter: loads a base address, then steps base+offset and
// wraps back to base after offset MAX_BURST.
module burst_addr_gen #(
    parameter int ADDR_W    = 8,
    parameter int MAX_BURST = 6
) (
    input  logic              CLK,
    input  logic              clear,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr
);

    localparam int OFS_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
    localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(MAX_BURST);

    logic [ADDR_W-1:0] base;
    logic [OFS_W-1:0]  offset;

    always_ff @(posedge CLK) begin
        if (clear) begin
            base   <= '0;
            offset <= '0;
            addr   <= '0;
        end else if (load) begin
            base   <= load_addr;
            offset <= '0;
            addr   <= load_addr;
        end else if (advance) begin
            if (offset == OFS_LAST) begin
                offset <= '0;
                addr   <= base;
            end else begin
                offset <= offset + OFS_W'(1);
                addr   <= addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_cmd_engine.sv
// Command/burst engine between the SPI word shifters and the register memory:
// decodes command words, runs auto-incrementing memory bursts, owns the channel enables.
module spi_cmd_engine
    import spi_cmd_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 8,
    parameter int                N_CH      = 4,
    parameter int                MAX_BURST = 6,
    parameter logic [DATA_W-1:0] REV_ID    = DATA_W'(16'h00A5)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CS_N,
    input  logic              RX_VALID,
    input  logic [DATA_W-1:0] RX_DATA,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              MEM_WE,
    output logic              MEM_RE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              EN_CLR_ALL,
    output logic [N_CH-1:0]   ENABLE,
    output logic              ERR
);

    state_e state_q;
    state_e state_nxt;

    logic              cs_n_q;
    logic              wr_mode_q;
    logic              wr_mode_nxt;
    logic              rd_vld_p2;
    logic              rd_pend;
    logic              rx_acc;
    logic [OP_W-1:0]   opcode;
    logic [CH_W-1:0]   ch;
    logic              ch_ok;
    logic [N_CH-1:0]   ch_mask;
    logic [DATA_W-1:0] status_word;

    logic en_set;
    logic en_clr;
    logic err_set;
    logic err_clr;
    logic tx_rev;
    logic tx_status;
    logic addr_load;
    logic rd_issue;
    logic wr_issue;
    logic addr_adv;

    // A read is in flight from the MEM_RE cycle until the data is captured.
    assign rd_pend = MEM_RE | rd_vld_p2;
    assign rx_acc  = RX_VALID & ~CS_N & ~rd_pend;
    assign opcode  = RX_DATA[DATA_W-1 -: OP_W];
    assign ch      = RX_DATA[CH_W-1:0];
    assign ch_ok   = (int'(ch) < N_CH);
    assign ch_mask = N_CH'(1) << ch;

    always_comb begin
        status_word = '0;
        status_word[ST_EN_LSB +: N_CH] = ENABLE;
        status_word[DATA_W-1-ST_STATE_FROM_MSB -: ST_STATE_W] = state_q;
        status_word[DATA_W-1-ST_ERR_FROM_MSB] = ERR;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        wr_mode_nxt = wr_mode_q;
        en_set      = 1'b0;
        en_clr      = 1'b0;
        err_set     = 1'b0;
        err_clr     = 1'b0;
        tx_rev      = 1'b0;
        tx_status   = 1'b0;
        addr_load   = 1'b0;
        rd_issue    = 1'b0;
        wr_issue    = 1'b0;

        if (CS_N) begin
            state_nxt = ST_IDLE;
        end else begin
            if (RX_VALID && rd_pend) begin
                err_set = 1'b1;
            end
            case (state_q)
                // Only a fresh chip-select fall starts a command; after a
                // command completes we sit here until CS_N cycles.
                ST_IDLE: begin
                    if (cs_n_q) begin
                        state_nxt = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (rx_acc) begin
                        state_nxt = ST_IDLE;
                        case (opcode)
                            OP_EN_SET: begin
                                if (ch_ok) en_set = 1'b1;
                                else       err_set = 1'b1;
                            end
                            OP_EN_CLR: begin
                                if (ch_ok) en_clr = 1'b1;
                                else       err_set = 1'b1;
                            end
                            OP_MEM_WR: begin
                                state_nxt   = ST_ADDR;
                                wr_mode_nxt = 1'b1;
                            end
                            OP_MEM_RD: begin
                                state_nxt   = ST_ADDR;
                                wr_mode_nxt = 1'b0;
                            end
                            OP_REV:     tx_rev    = 1'b1;
                            OP_STATUS:  tx_status = 1'b1;
                            OP_ERR_CLR: err_clr   = 1'b1;
                            default: begin
                                err_set = 1'b1;
                                tx_rev  = 1'b1;
                            end
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (rx_acc) begin
                        addr_load = 1'b1;
                        if (wr_mode_q) begin
                            state_nxt = ST_WDATA;
                        end else begin
                            state_nxt = ST_RDATA;
                            rd_issue  = 1'b1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (rx_acc) wr_issue = 1'b1;
                end
                ST_RDATA: begin
                    if (rx_acc) rd_issue = 1'b1;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Reads step the address before the strobe; writes step it after the strobe.
    assign addr_adv = (rd_issue & ~addr_load) | MEM_WE;

    burst_addr_gen #(
        .ADDR_W    (ADDR_W),
        .MAX_BURST (MAX_BURST)
    ) u_addr (
        .CLK       (CLK),
        .clear     (RESET),
        .load      (addr_load),
        .load_addr (RX_DATA[ADDR_W-1:0]),
        .advance   (addr_adv),
        .addr      (MEM_ADDR)
    );

    // stage p1: memory strobes; stage p2: read data returns and is captured
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cs_n_q    <= 1'b1;
            wr_mode_q <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_RE    <= 1'b0;
            rd_vld_p2 <= 1'b0;
            MEM_WDATA <= '0;
            TX_DATA   <= REV_ID;
            ENABLE    <= '0;
            ERR       <= 1'b0;
        end else begin
            cs_n_q    <= CS_N;
            wr_mode_q <= wr_mode_nxt;
            MEM_WE    <= wr_issue;
            MEM_RE    <= rd_issue;
            rd_vld_p2 <= MEM_RE;

            if (wr_issue) begin
                MEM_WDATA <= RX_DATA;
            end

            if (rd_vld_p2) begin
                TX_DATA <= MEM_RDATA;
            end else if (tx_status) begin
                TX_DATA <= status_word;
            end else if (tx_rev) begin
                TX_DATA <= REV_ID;
            end

            if (EN_CLR_ALL) begin
                ENABLE <= '0;
            end else if (en_set) begin
                ENABLE <= ENABLE | ch_mask;
            end else if (en_clr) begin
                ENABLE <= ENABLE & ~ch_mask;
            end

            if (err_set) begin
                ERR <= 1'b1;
            end else if (err_clr) begin
                ERR <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_cmd_engine.sv
// Randomised bench for spi_cmd_engine with a behavioural command/burst model
// and a simple registered-read memory.
module tb_spi_cmd_engine;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 8;
    localparam int N_CH      = 4;
    localparam int MAX_BURST = 6;
    localparam logic [15:0] REV = 16'h00A5;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CS_N;
    logic        RX_VALID;
    logic [15:0] RX_DATA;
    logic [15:0] TX_DATA;
    logic        MEM_WE;
    logic        MEM_RE;
    logic [7:0]  MEM_ADDR;
    logic [15:0] MEM_WDATA;
    logic [15:0] MEM_RDATA;
    logic        EN_CLR_ALL;
    logic [3:0]  ENABLE;
    logic        ERR;

    spi_cmd_engine #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .N_CH      (N_CH),
        .MAX_BURST (MAX_BURST),
        .REV_ID    (REV)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CS_N       (CS_N),
        .RX_VALID   (RX_VALID),
        .RX_DATA    (RX_DATA),
        .TX_DATA    (TX_DATA),
        .MEM_WE     (MEM_WE),
        .MEM_RE     (MEM_RE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_RDATA  (MEM_RDATA),
        .EN_CLR_ALL (EN_CLR_ALL),
        .ENABLE     (ENABLE),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] mem_seed;
    logic        mem_init;
    logic [15:0] mem     [256];
    logic [15:0] ref_mem [256];
    logic [15:0] wdata_tbl [16];

    logic [3:0]  m_en;
    logic        m_err;
    logic [15:0] m_tx;

    typedef struct { logic [7:0] a; logic [15:0] d; } wr_t;
    wr_t        wr_seen[$];
    wr_t        exp_wr[$];
    logic [7:0] rd_seen[$];
    logic [7:0] exp_rd[$];

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 40503) ^ mem_seed ^ 16'(i << 5);
    endfunction

    function automatic logic [7:0] baddr(input logic [7:0] base, input int k);
        return base + 8'(k % (MAX_BURST + 1));
    endfunction

    // Memory environment: registered read, one-cycle latency.
    always @(posedge CLK) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else begin
            if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
            if (MEM_RE) MEM_RDATA <= mem[MEM_ADDR];
        end
    end

    always @(negedge CLK) begin
        if (MEM_WE === 1'b1) wr_seen.push_back('{MEM_ADDR, MEM_WDATA});
        if (MEM_RE === 1'b1) rd_seen.push_back(MEM_ADDR);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic strobe(input logic [15:0] w);
        RX_DATA  = w;
        RX_VALID = 1'b1;
        tick(1);
        RX_VALID = 1'b0;
        tick(4);
    endtask

    task automatic cs_begin;
        CS_N = 1'b0;
        tick(2);
    endtask

    task automatic cs_end;
        CS_N = 1'b1;
        tick(2);
    endtask

    task automatic check_strobes(input string tag);
        chk({tag, "_nwr"}, wr_seen.size(), exp_wr.size());
        if (wr_seen.size() == exp_wr.size()) begin
            foreach (exp_wr[i]) begin
                chk({tag, "_wa"}, wr_seen[i].a, exp_wr[i].a);
                chk({tag, "_wd"}, wr_seen[i].d, exp_wr[i].d);
            end
        end
        chk({tag, "_nrd"}, rd_seen.size(), exp_rd.size());
        if (rd_seen.size() == exp_rd.size()) begin
            foreach (exp_rd[i]) chk({tag, "_ra"}, rd_seen[i], exp_rd[i]);
        end
        wr_seen.delete();
        exp_wr.delete();
        rd_seen.delete();
        exp_rd.delete();
    endtask

    task automatic model_cmd(input logic [15:0] w, input logic clr_all);
        logic [3:0] op;
        int ch;
        op = w[15:12];
        ch = int'(w[3:0]);
        case (op)
            4'd1: if (ch < N_CH) m_en = m_en | 4'(1 << ch); else m_err = 1'b1;
            4'd2: if (ch < N_CH) m_en = m_en & ~4'(1 << ch); else m_err = 1'b1;
            4'd5: m_tx = REV;
            4'd6: m_tx = {m_err, 3'd1, 8'd0, m_en};
            4'd7: m_err = 1'b0;
            default: begin
                m_err = 1'b1;
                m_tx  = REV;
            end
        endcase
        if (clr_all) m_en = 4'd0;
    endtask

    task automatic do_cmd(input logic [15:0] w, input logic clr_all);
        cs_begin;
        RX_DATA    = w;
        RX_VALID   = 1'b1;
        EN_CLR_ALL = clr_all;
        tick(1);
        RX_VALID   = 1'b0;
        EN_CLR_ALL = 1'b0;
        model_cmd(w, clr_all);
        chk("cmd_enable", ENABLE, m_en);
        chk("cmd_err", ERR, m_err);
        tick(4);
        chk("cmd_tx", TX_DATA, m_tx);
        cs_end;
        check_strobes("cmd");
    endtask

    task automatic wr_burst(input logic [7:0] base, input int n, input int stop_after);
        logic [7:0] a;
        cs_begin;
        strobe(16'h3000);
        strobe({8'($urandom), base});
        for (int k = 0; k < n; k++) begin
            if (k >= stop_after) CS_N = 1'b1;
            strobe(wdata_tbl[k]);
            if (k < stop_after) begin
                a = baddr(base, k);
                exp_wr.push_back('{a, wdata_tbl[k]});
                ref_mem[a] = wdata_tbl[k];
            end
        end
        cs_end;
        chk("wr_err", ERR, m_err);
        check_strobes("wr");
    endtask

    task automatic rd_burst(input logic [7:0] base, input int n);
        logic [7:0] a;
        cs_begin;
        strobe(16'h4000);
        strobe({8'($urandom), base});
        exp_rd.push_back(base);
        m_tx = ref_mem[base];
        chk("rd_tx0", TX_DATA, m_tx);
        for (int k = 1; k <= n; k++) begin
            strobe(16'($urandom));
            a = baddr(base, k);
            exp_rd.push_back(a);
            m_tx = ref_mem[a];
            chk("rd_tx", TX_DATA, m_tx);
        end
        cs_end;
        chk("rd_err", ERR, m_err);
        check_strobes("rd");
    endtask

    initial begin
        logic [3:0]  op;
        logic [7:0]  b;
        int          kind;
        int          n;
        int          stop;

        mem_seed   = 16'($urandom);
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        m_en       = 4'd0;
        m_err      = 1'b0;
        m_tx       = REV;
        RESET      = 1'b1;
        CS_N       = 1'b1;
        RX_VALID   = 1'b0;
        RX_DATA    = 16'h0;
        EN_CLR_ALL = 1'b0;
        mem_init   = 1'b1;
        tick(3);
        mem_init   = 1'b0;
        chk("rst_enable", ENABLE, 4'd0);
        chk("rst_err", ERR, 1'b0);
        chk("rst_we", MEM_WE, 1'b0);
        chk("rst_re", MEM_RE, 1'b0);
        chk("rst_addr", MEM_ADDR, 8'h00);
        chk("rst_wdata", MEM_WDATA, 16'h0000);
        chk("rst_tx", TX_DATA, REV);
        RESET = 1'b0;
        tick(2);

        do_cmd(16'h1002, 1'b0);
        chk("en_set_ch2", ENABLE, 4'b0100);
        do_cmd(16'h2002, 1'b0);
        chk("en_clr_ch2", ENABLE, 4'b0000);
        do_cmd(16'h1005, 1'b0);
        chk("en_set_ch5_err", ERR, 1'b1);
        do_cmd(16'h7000, 1'b0);

        wdata_tbl[0] = 16'hAAAA;
        wdata_tbl[1] = 16'hBBBB;
        wr_burst(8'h10, 2, 2);
        rd_burst(8'h20, 8);

        do_cmd(16'hF000, 1'b0);
        chk("inv_tx", TX_DATA, 16'h00A5);
        do_cmd(16'h1001, 1'b0);
        do_cmd(16'h6000, 1'b0);
        do_cmd(16'h7000, 1'b0);
        chk("err_clr", ERR, 1'b0);
        do_cmd(16'h5000, 1'b0);

        for (int k = 0; k < 4; k++) wdata_tbl[k] = 16'($urandom);
        wr_burst(8'h40, 4, 2);
        do_cmd(16'h1003, 1'b0);
        do_cmd(16'h1000, 1'b1);
        chk("clr_all_prio", ENABLE, 4'd0);

        // A word arriving while a read is still in flight is dropped and flagged.
        cs_begin;
        strobe(16'h4000);
        RX_DATA  = 16'h0030;
        RX_VALID = 1'b1;
        tick(1);
        RX_DATA  = 16'h1234;
        tick(1);
        RX_VALID = 1'b0;
        tick(4);
        exp_rd.push_back(8'h30);
        m_err = 1'b1;
        m_tx  = ref_mem[8'h30];
        chk("pend_err", ERR, m_err);
        chk("pend_tx", TX_DATA, m_tx);
        cs_end;
        check_strobes("pend");
        do_cmd(16'h7000, 1'b0);

        rd_burst(8'hFC, 10);
        rd_burst(8'h10, 3);

        for (int it = 0; it < 30; it++) begin
            kind = $urandom_range(0, 3);
            b    = 8'($urandom);
            if (kind <= 1) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'd3 || op == 4'd4) op = 4'd6;
                do_cmd({op, 8'($urandom), 4'($urandom)}, ($urandom_range(0, 7) == 0));
            end else if (kind == 2) begin
                n    = $urandom_range(1, 10);
                stop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n) : n;
                for (int k = 0; k < n; k++) wdata_tbl[k] = 16'($urandom);
                wr_burst(b, n, stop);
            end else begin
                rd_burst(b, $urandom_range(0, 9));
            end
        end

        // Reset arriving together with a read-advance word mid-burst.
        do_cmd(16'h1003, 1'b0);
        cs_begin;
        strobe(16'h4000);
        strobe(16'h0050);
        strobe(16'h0000);
        exp_rd.push_back(8'h50);
        exp_rd.push_back(8'h51);
        RX_VALID = 1'b1;
        RESET    = 1'b1;
        tick(1);
        RX_VALID = 1'b0;
        RESET    = 1'b0;
        m_en  = 4'd0;
        m_err = 1'b0;
        m_tx  = REV;
        chk("rstmid_enable", ENABLE, m_en);
        chk("rstmid_err", ERR, m_err);
        chk("rstmid_tx", TX_DATA, m_tx);
        chk("rstmid_re", MEM_RE, 1'b0);
        chk("rstmid_we", MEM_WE, 1'b0);
        chk("rstmid_addr", MEM_ADDR, 8'h00);
        chk("rstmid_wdata", MEM_WDATA, 16'h0000);
        tick(4);
        chk("rstmid_tx_hold", TX_DATA, m_tx);
        cs_end;
        check_strobes("rstmid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
